// File: rtl/param_counter.sv
// rtl/param_counter.sv - parametrised up/down modulo counter with tc/half pulses and wrap counter
// Optional trace: define PARAM_COUNTER_DISPLAY_EN to print step/wrap/half/load messages.
module param_counter #(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter int     SATURATE = 0,
    parameter int     WRAPS_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               half,
    output logic [WRAPS_W-1:0] wraps
);

    // One extra bit so MODULUS == 2**WIDTH still fits in the compare constants.
    localparam logic [WIDTH:0] MAX_C  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] HALF_C = (WIDTH+1)'(MODULUS / 2);

    logic [WIDTH-1:0]   count_nxt;
    logic               tc_nxt;
    logic               half_nxt;
    logic [WRAPS_W-1:0] wraps_nxt;
    logic               wrapped;
    logic [WIDTH:0]     load_ext;
    logic [WIDTH:0]     load_clamp;
    logic [WIDTH:0]     count_ext;

    assign load_ext   = {1'b0, load_val};
    assign load_clamp = (load_ext > MAX_C) ? MAX_C : load_ext;
    assign count_ext  = {1'b0, count};

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        half_nxt  = 1'b0;
        wraps_nxt = wraps;
        wrapped   = 1'b0;
        if (load) begin
            count_nxt = load_clamp[WIDTH-1:0];
        end else if (en) begin
            if (up) begin
                if (count_ext == MAX_C) begin
                    tc_nxt = 1'b1;
                    if (SATURATE == 0) begin
                        count_nxt = '0;
                        wrapped   = 1'b1;
                    end
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    tc_nxt = 1'b1;
                    if (SATURATE == 0) begin
                        count_nxt = MAX_C[WIDTH-1:0];
                        wrapped   = 1'b1;
                    end
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
            half_nxt = ({1'b0, count_nxt} == HALF_C);
            // Wrap counter sticks at all-ones instead of rolling over.
            if (wrapped && (wraps != {WRAPS_W{1'b1}}))
                wraps_nxt = wraps + WRAPS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            half  <= 1'b0;
            wraps <= '0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            half  <= half_nxt;
            wraps <= wraps_nxt;
`ifdef PARAM_COUNTER_DISPLAY_EN
            if (load) begin
                $display("Load: %0d", count_nxt);
            end else if (en) begin
                $display("Count: %0d (0x%h)", count_nxt, count_nxt);
                if (wrapped)
                    $display("Counter wrapped, wraps=%0d", wraps_nxt);
                if (half_nxt)
                    $display("Halfway point reached!");
            end
`endif
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - directed self-checking bench for param_counter
module tb_param_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] en = '0;
    logic [4:0] up = '0;
    logic [4:0] load = '0;
    logic [7:0] load_val = '0;

    logic [3:0] c0;  logic t0, h0;  logic [7:0] w0;
    logic [7:0] c1;  logic t1, h1;  logic [7:0] w1;
    logic [7:0] c2;  logic t2, h2;  logic [7:0] w2;
    logic [7:0] c3;  logic t3, h3;  logic [7:0] w3;
    logic [2:0] c4;  logic t4, h4;  logic [1:0] w4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4), .MODULUS(16)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .up(up[0]), .load(load[0]),
        .load_val(load_val[3:0]), .count(c0), .tc(t0), .half(h0), .wraps(w0));
    param_counter #(.WIDTH(8), .MODULUS(10)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .up(up[1]), .load(load[1]),
        .load_val(load_val), .count(c1), .tc(t1), .half(h1), .wraps(w1));
    param_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .up(up[2]), .load(load[2]),
        .load_val(load_val), .count(c2), .tc(t2), .half(h2), .wraps(w2));
    param_counter #(.WIDTH(8), .MODULUS(100)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en[3]), .up(up[3]), .load(load[3]),
        .load_val(load_val), .count(c3), .tc(t3), .half(h3), .wraps(w3));
    param_counter #(.WIDTH(3), .MODULUS(8), .WRAPS_W(2)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en[4]), .up(up[4]), .load(load[4]),
        .load_val(load_val[2:0]), .count(c4), .tc(t4), .half(h4), .wraps(w4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #12;
        check("rst_count", 32'(c0), 0);
        check("rst_tc", 32'(t0), 0);
        check("rst_half", 32'(h0), 0);
        check("rst_wraps", 32'(w0), 0);
        rst_n = 1'b1;
        #2;

        // 1: WIDTH=4, MODULUS=16, 17 up steps
        en[0] = 1'b1; up[0] = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check($sformatf("t1_count_%0d", i), 32'(c0), 32'(i % 16));
            check($sformatf("t1_tc_%0d", i), 32'(t0), (i == 16) ? 1 : 0);
            check($sformatf("t1_half_%0d", i), 32'(h0), (i == 8) ? 1 : 0);
        end
        check("t1_wraps", 32'(w0), 1);
        en[0] = 1'b0;
        tick();
        check("t1_hold_count", 32'(c0), 1);
        check("t1_hold_tc", 32'(t0), 0);

        // 5: async reset mid-cycle at count=5
        load[0] = 1'b1; load_val = 8'd5;
        tick();
        load[0] = 1'b0;
        check("t5_loaded", 32'(c0), 5);
        check("t5_load_tc", 32'(t0), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_count", 32'(c0), 0);
        check("t5_async_wraps", 32'(w0), 0);
        #1;
        rst_n = 1'b1;
        en[0] = 1'b1; up[0] = 1'b1;
        tick();
        check("t5_first_step", 32'(c0), 1);
        en[0] = 1'b0;

        // 2: MODULUS=10 down from 0, then down to the halfway point
        en[1] = 1'b1; up[1] = 1'b0;
        tick();
        check("t2_count", 32'(c1), 9);
        check("t2_tc", 32'(t1), 1);
        check("t2_wraps", 32'(w1), 1);
        tick();
        check("t2_count2", 32'(c1), 8);
        check("t2_tc2", 32'(t1), 0);
        tick(); tick();
        check("t2_half_pre", 32'(h1), 0);
        tick();
        check("t2_count5", 32'(c1), 5);
        check("t2_half_down", 32'(h1), 1);
        en[1] = 1'b0;
        tick();
        check("t2_half_drop", 32'(h1), 0);

        // 3: SATURATE=1, MODULUS=10, held at top
        load[2] = 1'b1; load_val = 8'd9;
        tick();
        load[2] = 1'b0;
        check("t3_load", 32'(c2), 9);
        check("t3_load_tc", 32'(t2), 0);
        en[2] = 1'b1; up[2] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("t3_count_%0d", i), 32'(c2), 9);
            check($sformatf("t3_tc_%0d", i), 32'(t2), 1);
        end
        check("t3_wraps", 32'(w2), 0);
        up[2] = 1'b0;
        tick();
        check("t3_down", 32'(c2), 8);
        check("t3_down_tc", 32'(t2), 0);
        en[2] = 1'b0;

        // 4: load beats en, value clamped to MODULUS-1
        load[3] = 1'b1; en[3] = 1'b1; up[3] = 1'b1; load_val = 8'd200;
        tick();
        check("t4_clamp", 32'(c3), 99);
        check("t4_tc", 32'(t3), 0);
        load[3] = 1'b0;
        tick();
        check("t4_wrap_count", 32'(c3), 0);
        check("t4_wrap_tc", 32'(t3), 1);
        check("t4_wraps", 32'(w3), 1);
        en[3] = 1'b0;

        // 6: WRAPS_W=2 saturating wrap counter over 5 full wraps
        en[4] = 1'b1; up[4] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            for (int j = 0; j < 8; j++) tick();
            check($sformatf("t6_wraps_%0d", k), 32'(w4), (k > 3) ? 3 : 32'(k));
            check($sformatf("t6_count_%0d", k), 32'(c4), 0);
            check($sformatf("t6_tc_%0d", k), 32'(t4), 1);
        end
        en[4] = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
